// File: rtl/einstein_sd_responder.sv
// Sector responder for the sd_lba/sd_rd/sd_wr/sd_ack handshake, backed by a byte-wide image RAM.
// Define SD_RESP_WPROT_EN to add the wprot input that suppresses RAM writes.
module einstein_sd_responder #(
  parameter int         LBA_W   = 9,
  parameter int         SECTORS = 400,
  parameter logic [7:0] FILL    = 8'hE5
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [31:0]      sd_lba,
  input  logic [1:0]       sd_rd,
  input  logic [1:0]       sd_wr,
  output logic             sd_ack,
  output logic [8:0]       sd_buff_addr,
  output logic [7:0]       sd_buff_dout,
  output logic             sd_buff_wr,
  input  logic [7:0]       sd_buff_din,
`ifdef SD_RESP_WPROT_EN
  input  logic             wprot,
`endif
  output logic [LBA_W+9:0] mem_addr,
  output logic             mem_wr,
  output logic [7:0]       mem_din,
  input  logic [7:0]       mem_dout
);

  // state  | meaning
  // S_IDLE | waiting for any sd_rd/sd_wr bit
  // S_XFER | ack high, one byte per cycle, counter 0..512
  // S_DONE | ack low, waiting for the requester to drop its request
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             drive_q, is_rd_q, oor_q, wr_block_q;
  logic [LBA_W-1:0] lba_q;
  logic [9:0]       n_q;
  logic             rd_slot_q, wr_slot_q;
  logic             req_any, accept, byte_step, last_byte;
  logic             drive_sel, rd_sel, oor_sel, prot_sel;

  assign req_any   = |(sd_rd | sd_wr);
  assign drive_sel = ~(sd_rd[0] | sd_wr[0]);
  assign rd_sel    = sd_rd[drive_sel];
  assign oor_sel   = sd_lba >= 32'(SECTORS);
  assign last_byte = (n_q == 10'd512);

`ifdef SD_RESP_WPROT_EN
  assign prot_sel = wprot;
`else
  assign prot_sel = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_any)   state_nxt = S_XFER;
      S_XFER:  if (last_byte) state_nxt = S_DONE;
      S_DONE:  if (!req_any)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sd_ack    = (state == S_XFER);
    accept    = (state == S_IDLE) && req_any;
    byte_step = (state == S_XFER) && !last_byte;
  end

  // RAM read data and requester write data both arrive one cycle after their address, so they pass straight through
  assign sd_buff_wr   = rd_slot_q;
  assign sd_buff_dout = rd_slot_q ? (oor_q ? FILL : mem_dout) : 8'h00;
  assign mem_wr       = wr_slot_q & ~wr_block_q;
  assign mem_din      = wr_slot_q ? sd_buff_din : 8'h00;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      drive_q      <= 1'b0;
      is_rd_q      <= 1'b0;
      oor_q        <= 1'b0;
      wr_block_q   <= 1'b0;
      lba_q        <= '0;
      n_q          <= '0;
      rd_slot_q    <= 1'b0;
      wr_slot_q    <= 1'b0;
      sd_buff_addr <= '0;
      mem_addr     <= '0;
    end else begin
      rd_slot_q <= byte_step & is_rd_q;
      wr_slot_q <= byte_step & ~is_rd_q;
      if (accept) begin
        drive_q      <= drive_sel;
        is_rd_q      <= rd_sel;
        oor_q        <= oor_sel;
        wr_block_q   <= oor_sel | prot_sel;
        lba_q        <= sd_lba[LBA_W-1:0];
        n_q          <= '0;
        sd_buff_addr <= '0;
        mem_addr     <= {drive_sel, sd_lba[LBA_W-1:0], 9'd0};
      end else if (byte_step) begin
        n_q          <= n_q + 10'd1;
        // reads run the RAM address one byte ahead; writes run the buffer address one byte ahead
        sd_buff_addr <= is_rd_q ? n_q[8:0] : n_q[8:0] + 9'd1;
        mem_addr     <= {drive_q, lba_q, (is_rd_q ? n_q[8:0] + 9'd1 : n_q[8:0])};
      end
    end
  end

endmodule

// File: tb/tb_einstein_sd_responder.sv
// Randomised bench for einstein_sd_responder: models the image RAM and requester buffer, and
// predicts every strobe from a shadow sector image. Covers SD_RESP_WPROT_EN when it is defined.
module tb_einstein_sd_responder;
  localparam int LBA_W = 9;
  localparam int AW    = LBA_W + 10;
  localparam int MEM_N = 1 << AW;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic [31:0]   sd_lba  = '0;
  logic [1:0]    sd_rd   = '0;
  logic [1:0]    sd_wr   = '0;
  logic          sd_ack;
  logic [8:0]    sd_buff_addr;
  logic [7:0]    sd_buff_dout;
  logic          sd_buff_wr;
  logic [7:0]    sd_buff_din;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
`ifdef SD_RESP_WPROT_EN
  logic          wprot = 1'b0;
`endif

  einstein_sd_responder #(.LBA_W(LBA_W), .SECTORS(400), .FILL(8'hE5)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
`ifdef SD_RESP_WPROT_EN
    .wprot        (wprot),
`endif
    .mem_addr     (mem_addr),
    .mem_wr       (mem_wr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] ram     [MEM_N];
  logic [7:0] ref_mem [MEM_N];
  logic [7:0] wbuf    [512];

  // image RAM and requester buffer, both with one cycle of read latency
  initial begin
    for (int i = 0; i < MEM_N; i++) ram[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk_sys);
      mem_dout    <= ram[mem_addr];
      sd_buff_din <= wbuf[sd_buff_addr];
      if (mem_wr) ram[mem_addr] = mem_din;
    end
  end

  typedef struct { int cyc; int addr; int data; } ev_t;
  ev_t  rd_q[$];
  ev_t  wr_q[$];
  int   rise_q[$];
  int   fall_q[$];
  int   cyc = 0;
  logic ack_prev = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (sd_buff_wr) rd_q.push_back('{cyc, int'(sd_buff_addr), int'(sd_buff_dout)});
    if (mem_wr)     wr_q.push_back('{cyc, int'(mem_addr), int'(mem_din)});
    if (sd_ack && !ack_prev) rise_q.push_back(cyc);
    if (!sd_ack && ack_prev) fall_q.push_back(cyc);
    ack_prev = sd_ack;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  // transfer starting at cycle t0 (ack rise): byte k belongs at cycle t0+1+k
  task automatic verify(string tag, bit is_rd, bit oor, bit blk, int base, int t0, int r0, int w0);
    int  nr, nw, errs;
    ev_t e;
    nr = rd_q.size() - r0;
    nw = wr_q.size() - w0;
    check({tag, " strobes"}, nr, is_rd ? 512 : 0);
    check({tag, " mem_wr"}, nw, (!is_rd && !blk) ? 512 : 0);
    errs = 0;
    for (int k = 0; k < nr && k < 512; k++) begin
      e = rd_q[r0+k];
      if (e.cyc != t0 + 1 + k || e.addr != k ||
          e.data != int'(oor ? 8'hE5 : ref_mem[base+k])) errs++;
    end
    for (int k = 0; k < nw && k < 512; k++) begin
      e = wr_q[w0+k];
      if (e.cyc != t0 + 1 + k || e.addr != base + k || e.data != int'(wbuf[k])) errs++;
    end
    check({tag, " bytes"}, errs, 0);
    if (!is_rd && !blk)
      for (int k = 0; k < 512; k++) ref_mem[base+k] = wbuf[k];
  endtask

  task automatic run_xfer(string tag, logic [1:0] rd, logic [1:0] wr, logic [31:0] lba,
                          bit wp, bit tog, bit rnd);
    int drv, base, t_req, rise, fall, r0, w0, rs0, fs0;
    bit is_rd, oor, blk, ok;
    drv   = (rd[0] || wr[0]) ? 0 : 1;
    is_rd = rd[drv];
    oor   = (lba >= 32'd400);
    blk   = oor || wp;
    base  = (drv << 18) | (int'(lba[8:0]) << 9);
    for (int k = 0; k < 512; k++) wbuf[k] = rnd ? 8'($urandom) : 8'(k);
    r0  = rd_q.size();
    w0  = wr_q.size();
    rs0 = rise_q.size();
    fs0 = fall_q.size();
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
`ifdef SD_RESP_WPROT_EN
    wprot = wp;
`endif
    t_req = cyc;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      ok = fall_q.size() > fs0;
`ifdef SD_RESP_WPROT_EN
      if (tog && i == 200) wprot = ~wprot;
`endif
    end
    check({tag, " done"}, ok, 1);
    repeat (4) tick();
    sd_rd = '0;
    sd_wr = '0;
`ifdef SD_RESP_WPROT_EN
    wprot = 1'b0;
`endif
    repeat (2) tick();
    rise = (rise_q.size() > rs0) ? rise_q[rs0] : -1;
    fall = (fall_q.size() > fs0) ? fall_q[fs0] : -1;
    check({tag, " rise"}, rise, t_req + 1);
    check({tag, " len"}, fall - rise, 513);
    check({tag, " nrise"}, rise_q.size() - rs0, 1);
    verify(tag, is_rd, oor, blk, base, t_req + 1, r0, w0);
  endtask

  initial begin
    int         w0, w1, r0, fs0, rs1, rel;
    bit         ok;
    logic [1:0] rrd, rwr;
    logic [31:0] rlba;
    bit         rwp;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    for (int k = 0; k < 512; k++) wbuf[k] = 8'h00;

    repeat (3) tick();
    check("reset sd_ack", sd_ack, 0);
    check("reset sd_buff_wr", sd_buff_wr, 0);
    check("reset sd_buff_addr", sd_buff_addr, 0);
    check("reset sd_buff_dout", sd_buff_dout, 0);
    check("reset mem_wr", mem_wr, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_din", mem_din, 0);
    reset = 1'b0;
    repeat (2) tick();

    run_xfer("rd d0 l3", 2'b01, 2'b00, 32'd3, 0, 0, 1);
    run_xfer("wr d1 l7", 2'b00, 2'b10, 32'd7, 0, 0, 0);
    run_xfer("rd d1 l7", 2'b10, 2'b00, 32'd7, 0, 0, 1);
    run_xfer("prio d0", 2'b11, 2'b01, 32'd5, 0, 0, 1);
    run_xfer("prio d1", 2'b10, 2'b00, 32'd5, 0, 0, 1);
    run_xfer("rd oor400", 2'b01, 2'b00, 32'd400, 0, 0, 1);
    run_xfer("rd last399", 2'b01, 2'b00, 32'd399, 0, 0, 1);
    run_xfer("wr oor500", 2'b00, 2'b01, 32'd500, 0, 0, 1);
    run_xfer("rd hi oor", 2'b10, 2'b00, 32'h0001_0003, 0, 0, 1);

    // reset after the 100th byte of a write, with the request still held
    for (int k = 0; k < 512; k++) wbuf[k] = 8'($urandom);
    w0 = wr_q.size();
    sd_lba = 32'd10;
    sd_rd  = 2'b00;
    sd_wr  = 2'b01;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (wr_q.size() - w0) >= 100;
    end
    check("rst reach100", ok, 1);
    reset = 1'b1;
    tick();
    check("rst sd_ack", sd_ack, 0);
    check("rst mem_wr", mem_wr, 0);
    check("rst sd_buff_wr", sd_buff_wr, 0);
    check("rst wr count", wr_q.size() - w0, 100);
    reset = 1'b0;
    rel = cyc;
    r0  = rd_q.size();
    w1  = wr_q.size();
    fs0 = fall_q.size();
    rs1 = rise_q.size();
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      ok = fall_q.size() > fs0;
    end
    check("rst redo done", ok, 1);
    check("rst reaccept", (rise_q.size() > rs1) ? rise_q[rs1] : -1, rel + 1);
    sd_wr = 2'b00;
    repeat (2) tick();
    verify("rst redo", 0, 0, 0, 10 << 9, rel + 1, r0, w1);

`ifdef SD_RESP_WPROT_EN
    run_xfer("wprot wr l0", 2'b00, 2'b01, 32'd0, 1, 1, 1);
    run_xfer("wprot rd l0", 2'b01, 2'b00, 32'd0, 0, 0, 1);
`endif

    for (int it = 0; it < 12; it++) begin
      rrd = 2'($urandom_range(0, 3));
      rwr = 2'($urandom_range(0, 3));
      if (rrd == 2'b00 && rwr == 2'b00) rrd = 2'b01;
      case ($urandom_range(0, 9))
        7:       rlba = 32'($urandom_range(400, 511));
        8:       rlba = $urandom | 32'h8000_0000;
        9:       rlba = 32'd399;
        default: rlba = 32'($urandom_range(0, 7));
      endcase
      rwp = 0;
`ifdef SD_RESP_WPROT_EN
      rwp = 1'($urandom_range(0, 1));
`endif
      run_xfer($sformatf("rnd%0d", it), rrd, rwr, rlba, rwp, 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
